// File: rtl/mul_seq.sv
// Multi-cycle shift-add multiplier for the MUL/MLA/UMULL/SMULL/UMLAL/SMLAL families.
// Magnitudes are multiplied STEP bits per cycle; sign and accumulate are applied in FINISH.
module mul_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] B_In,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] Acc_Hi,
  input  logic [WIDTH-1:0] Acc_Lo,
  input  logic             U,
  input  logic             ACC,
  input  logic             LONG,
  input  logic             start,
  input  logic             MUL_HiLo,
  output logic [WIDTH-1:0] B_Out,
  output logic             busy,
  output logic             done,
  output logic             N_flag,
  output logic             Z_flag
);

  localparam int W2    = 2 * WIDTH;
  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t           state, state_nx;
  logic [W2-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [W2-1:0]    partial;
  logic [W2-1:0]    acc_q;
  logic             neg_q;
  logic             long_q;
  logic [CNT_W-1:0] cnt;
  logic [W2-1:0]    res;

  logic [WIDTH-1:0] mag_b, mag_c;
  logic [W2-1:0]    step_sum;
  logic [W2-1:0]    p_fin;
  logic [W2-1:0]    res_nx;
  logic             n_nx, z_nx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (start) state_nx = S_RUN;
      S_RUN:    if (cnt == CNT_W'(N - 1)) state_nx = S_FINISH;
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // 0x80..0 negates to itself, which read unsigned is exactly 2^(W-1).
  always_comb begin
    mag_b = (U && B_In[WIDTH-1]) ? -B_In : B_In;
    mag_c = (U && C[WIDTH-1])    ? -C    : C;
  end

  // mcand already carries the cycle_index*STEP shift, so only the digit weight is added here.
  always_comb begin
    step_sum = '0;
    for (int i = 0; i < STEP; i++) begin
      if (mplier[i]) step_sum = step_sum + (mcand << i);
    end
  end

  always_comb begin
    p_fin = neg_q ? -partial : partial;
    if (long_q) begin
      res_nx = p_fin + acc_q;
      n_nx   = res_nx[W2-1];
      z_nx   = (res_nx == '0);
    end else begin
      res_nx = {{WIDTH{1'b0}}, p_fin[WIDTH-1:0] + acc_q[WIDTH-1:0]};
      n_nx   = res_nx[WIDTH-1];
      z_nx   = (res_nx[WIDTH-1:0] == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      partial <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      long_q  <= 1'b0;
      cnt     <= '0;
      res     <= '0;
      done    <= 1'b0;
      N_flag  <= 1'b0;
      Z_flag  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mcand   <= {{WIDTH{1'b0}}, mag_b};
            mplier  <= mag_c;
            partial <= '0;
            cnt     <= '0;
            neg_q   <= U & (B_In[WIDTH-1] ^ C[WIDTH-1]);
            long_q  <= LONG;
            if (!ACC)      acc_q <= '0;
            else if (LONG) acc_q <= {Acc_Hi, Acc_Lo};
            else           acc_q <= {{WIDTH{1'b0}}, Acc_Lo};
          end
        end
        S_RUN: begin
          partial <= partial + step_sum;
          mcand   <= mcand << STEP;
          mplier  <= mplier >> STEP;
          cnt     <= cnt + CNT_W'(1);
        end
        S_FINISH: begin
          res    <= res_nx;
          N_flag <= n_nx;
          Z_flag <= z_nx;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state != S_IDLE);
  assign B_Out = MUL_HiLo ? res[W2-1:WIDTH] : res[WIDTH-1:0];

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: three instances (STEP=1,2,4) share inputs; results are
// compared against a 64-bit arithmetic reference and hand-computed vectors.
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] b_in, c_in, acc_hi, acc_lo;
  logic        u, acc, lng, start, mul_hilo;

  logic [31:0] bo     [3];
  logic        busy_a [3];
  logic        done_a [3];
  logic        n_a    [3];
  logic        z_a    [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mul_seq #(.WIDTH(32), .STEP(1 << g)) u_dut (
      .clk(clk), .rst(rst), .B_In(b_in), .C(c_in), .Acc_Hi(acc_hi), .Acc_Lo(acc_lo),
      .U(u), .ACC(acc), .LONG(lng), .start(start), .MUL_HiLo(mul_hilo),
      .B_Out(bo[g]), .busy(busy_a[g]), .done(done_a[g]), .N_flag(n_a[g]), .Z_flag(z_a[g])
    );
  end

  typedef struct {
    logic [31:0] b, c, ah, al;
    bit          u, acc, lng;
    logic [63:0] res;
    bit          n, z;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: sign/zero extend to 64 bits and multiply; accumulate per mode.
  function automatic vec_t with_expect(input vec_t v);
    logic [63:0] pa, pc, prod, r;
    pa   = v.u ? {{32{v.b[31]}}, v.b} : {32'h0, v.b};
    pc   = v.u ? {{32{v.c[31]}}, v.c} : {32'h0, v.c};
    prod = pa * pc;
    if (v.lng) begin
      r   = prod + (v.acc ? {v.ah, v.al} : 64'h0);
      v.n = r[63];
      v.z = (r == 64'h0);
    end else begin
      r   = {32'h0, prod[31:0] + (v.acc ? v.al : 32'h0)};
      v.n = r[31];
      v.z = (r[31:0] == 32'h0);
    end
    v.res = r;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    b_in = v.b; c_in = v.c; acc_hi = v.ah; acc_lo = v.al;
    u = v.u; acc = v.acc; lng = v.lng;
  endtask

  // Issue one op; with extra=1, start is re-pulsed at edges 3 and 10.
  // The STEP=4 instance is idle again by edge 10 and legitimately restarts, so it is skipped then.
  task automatic run_op(input vec_t v, input bit extra, input string tag);
    int lat [3];
    int cnt [3];
    logic [31:0] hi [3];
    logic [31:0] lo [3];
    for (int i = 0; i < 3; i++) begin lat[i] = 0; cnt[i] = 0; end
    @(negedge clk);
    drive(v);
    start = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      start = extra && (e == 3 || e == 10);
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (done_a[i]) begin
          cnt[i]++;
          if (lat[i] == 0) lat[i] = e;
        end
      end
    end
    start = 1'b0;
    mul_hilo = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) hi[i] = bo[i];
    mul_hilo = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) lo[i] = bo[i];
    for (int i = 0; i < 3; i++) begin
      if (extra && i == 2) continue;
      check($sformatf("%s s%0d latency", tag, 1 << i), 64'(lat[i]), 64'((32 >> i) + 1));
      check($sformatf("%s s%0d done_cnt", tag, 1 << i), 64'(cnt[i]), 64'd1);
      check($sformatf("%s s%0d hi", tag, 1 << i), {32'h0, hi[i]}, {32'h0, v.res[63:32]});
      check($sformatf("%s s%0d lo", tag, 1 << i), {32'h0, lo[i]}, {32'h0, v.res[31:0]});
      check($sformatf("%s s%0d n", tag, 1 << i), 64'(n_a[i]), 64'(v.n));
      check($sformatf("%s s%0d z", tag, 1 << i), 64'(z_a[i]), 64'(v.z));
      check($sformatf("%s s%0d busy", tag, 1 << i), 64'(busy_a[i]), 64'd0);
    end
  endtask

  initial begin
    int   edges [$];
    int   dcnt;
    vec_t rv;

    //         b             c             ah            al            u  acc lng res                     n  z
    tbl[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 0, 1, 64'hFFFFFFFE_00000001, 1, 0};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000002, 32'h0,        32'h0,        1, 0, 1, 64'hFFFFFFFF_FFFFFFFE, 1, 0};
    tbl[2] = '{32'h80000000, 32'h80000000, 32'h0,        32'h0,        1, 0, 1, 64'h40000000_00000000, 0, 0};
    tbl[3] = '{32'h00000003, 32'h00000005, 32'h0,        32'hFFFFFFF1, 0, 1, 0, 64'h0,                 0, 1};
    tbl[4] = '{32'h80000000, 32'h80000000, 32'hC0000000, 32'h0,        1, 1, 1, 64'h0,                 0, 1};
    tbl[5] = '{32'h00000007, 32'hFFFFFFFD, 32'h0,        32'h0,        1, 0, 0, 64'h00000000_FFFFFFEB, 1, 0};
    tbl[6] = '{32'h00000000, 32'h0000007B, 32'h0,        32'h0,        0, 0, 1, 64'h0,                 0, 1};
    tbl[7] = '{32'h00000002, 32'h00000003, 32'h00000001, 32'hFFFFFFFF, 0, 1, 1, 64'h00000002_00000005, 0, 0};

    rst = 1'b1; start = 1'b0; mul_hilo = 1'b0;
    drive(tbl[0]);
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 64'(busy_a[1]), 64'd0);
    check("rst done", 64'(done_a[1]), 64'd0);
    check("rst n",    64'(n_a[1]),    64'd0);
    check("rst z",    64'(z_a[1]),    64'd0);
    check("rst lo",   {32'h0, bo[1]}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) run_op(tbl[k], 1'b0, $sformatf("vec%0d", k));

    // Re-pulsed start while busy must not disturb the operation in flight.
    run_op(tbl[1], 1'b1, "ignore_start");

    // Held start: STEP=2 instance completes one op every N+2 = 18 cycles.
    @(negedge clk);
    drive(tbl[0]);
    start = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 75; e++) begin
      @(posedge clk);
      #1;
      if (done_a[1]) edges.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    check("b2b count", 64'(edges.size()), 64'd4);
    for (int k = 0; k < edges.size() && k < 4; k++)
      check($sformatf("b2b edge%0d", k), 64'(edges[k]), 64'(17 + 18 * k));
    repeat (40) @(posedge clk);

    // Asynchronous reset mid-RUN after a completed op left Res nonzero.
    run_op(tbl[0], 1'b0, "pre_rst");
    @(negedge clk);
    drive(tbl[1]);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst busy", 64'(busy_a[1]), 64'd0);
    check("arst lo",   {32'h0, bo[1]}, 64'h0);
    mul_hilo = 1'b1;
    #1;
    check("arst hi",   {32'h0, bo[1]}, 64'h0);
    check("arst n",    64'(n_a[1]), 64'd0);
    check("arst done", 64'(done_a[1]), 64'd0);
    mul_hilo = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) if (done_a[i]) dcnt++;
    end
    check("arst no done", 64'(dcnt), 64'd0);
    run_op(tbl[2], 1'b0, "post_rst");

    // Randomised operands, modes and accumulators against the reference.
    for (int k = 0; k < 20; k++) begin
      rv.b   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      rv.c   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      rv.ah  = $urandom;
      rv.al  = $urandom;
      rv.u   = 1'($urandom_range(0, 1));
      rv.acc = 1'($urandom_range(0, 1));
      rv.lng = 1'($urandom_range(0, 1));
      run_op(with_expect(rv), 1'b0, $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
